// File: rtl/udp_rx_fifo.sv
// udp_rx_fifo: receive-side UDP payload buffer with two ping-pong banks.
// Each frame from the RX parser is written into the free bank and held there until
// the parser's checksum/length verdict arrives. Good frames are streamed to the user
// in arrival order. Bad or oversize frames are dropped without emitting any beat.
//
// Ports:
//   aclk, aresetn          clock; synchronous active-low reset
//   s_axis_*               payload stream from the parser (tdata/tvalid/tlast/tready)
//   frame_ok, frame_err    one-cycle verdict pulses for the current frame
//   m_axis_*               payload stream to the user (tdata/tvalid/tlast/tready)
//   rx_len                 byte length of the frame being output
//   drop_cnt               saturating count of discarded frames
module udp_rx_fifo #(
  parameter int unsigned BANK_DEPTH = 256,
  parameter int unsigned DROP_CNT_W = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [31:0]           s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  input  logic                  frame_ok,
  input  logic                  frame_err,
  output logic [31:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [15:0]           rx_len,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int unsigned AW = $clog2(BANK_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {WrData, WrVerdict, WrDiscard} wr_state_e;
  typedef enum logic {RdIdle, RdStream} rd_state_e;

  logic [31:0] mem [2*BANK_DEPTH];

  wr_state_e             wr_state_q, wr_state_d;
  rd_state_e             rd_state_q, rd_state_d;
  logic [1:0]            full_q, full_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [AW-1:0]         wcnt_q, wcnt_d;
  logic [LW-1:0]         len_words_q [2];
  logic [LW-1:0]         len_words_d [2];
  logic [AW-1:0]         rptr_q, rptr_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic [15:0]           rx_len_q, rx_len_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [31:0]           tdata_q;
  // Holds tready low for the first cycle after reset.
  logic                  run_q;

  logic          s_hs;
  logic          commit, drop, free;
  logic          wr_en, rd_en;
  logic [AW:0]   wr_addr, rd_addr;
  logic [AW-1:0] rd_idx;

  assign s_axis_tready = run_q && ((wr_state_q == WrDiscard) ||
                                   (wr_state_q == WrData && !full_q[wr_bank_q]));
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign wr_addr       = {wr_bank_q, wcnt_q};
  assign rd_addr       = {rd_bank_q, rd_idx};

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign rx_len        = rx_len_q;
  assign drop_cnt      = drop_cnt_q;

  // Write side: fill a bank, then wait for the verdict.
  always_comb begin
    wr_state_d  = wr_state_q;
    wcnt_d      = wcnt_q;
    len_words_d = len_words_q;
    commit      = 1'b0;
    drop        = 1'b0;
    wr_en       = 1'b0;
    unique case (wr_state_q)
      WrData: begin
        if (s_hs) begin
          wr_en = 1'b1;
          if (s_axis_tlast) begin
            len_words_d[wr_bank_q] = LW'(wcnt_q) + LW'(1);
            wcnt_d = '0;
            // A verdict in the tlast cycle resolves immediately; both pulses means drop.
            if (frame_err) begin
              drop = 1'b1;
            end else if (frame_ok) begin
              commit = 1'b1;
            end else begin
              wr_state_d = WrVerdict;
            end
          end else if (wcnt_q == AW'(BANK_DEPTH - 1)) begin
            wr_state_d = WrDiscard;
            wcnt_d     = '0;
          end else begin
            wcnt_d = wcnt_q + AW'(1);
          end
        end
      end
      WrVerdict: begin
        if (frame_err) begin
          drop       = 1'b1;
          wr_state_d = WrData;
        end else if (frame_ok) begin
          commit     = 1'b1;
          wr_state_d = WrData;
        end
      end
      WrDiscard: begin
        if (s_hs && s_axis_tlast) begin
          drop       = 1'b1;
          wr_state_d = WrData;
        end
      end
      default: wr_state_d = WrData;
    endcase
  end

  // Read side: the output data register doubles as the memory read register.
  always_comb begin
    rd_state_d = rd_state_q;
    rptr_d     = rptr_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    rx_len_d   = rx_len_q;
    free       = 1'b0;
    rd_en      = 1'b0;
    rd_idx     = rptr_q + AW'(1);
    unique case (rd_state_q)
      RdIdle: begin
        if (full_q[rd_bank_q]) begin
          rd_en      = 1'b1;
          rd_idx     = '0;
          rptr_d     = '0;
          tvalid_d   = 1'b1;
          tlast_d    = (len_words_q[rd_bank_q] == LW'(1));
          rx_len_d   = 16'({len_words_q[rd_bank_q], 2'b00});
          rd_state_d = RdStream;
        end
      end
      RdStream: begin
        if (m_axis_tready) begin
          if (tlast_q) begin
            tvalid_d   = 1'b0;
            tlast_d    = 1'b0;
            free       = 1'b1;
            rd_state_d = RdIdle;
          end else begin
            rd_en   = 1'b1;
            rptr_d  = rd_idx;
            tlast_d = ((LW'(rptr_q) + LW'(2)) == len_words_q[rd_bank_q]);
          end
        end
      end
      default: rd_state_d = RdIdle;
    endcase
  end

  // Commit and free always target different banks, so both can apply together.
  always_comb begin
    full_d = full_q;
    if (commit) full_d[wr_bank_q] = 1'b1;
    if (free)   full_d[rd_bank_q] = 1'b0;
    wr_bank_d = wr_bank_q ^ commit;
    rd_bank_d = rd_bank_q ^ free;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != {DROP_CNT_W{1'b1}})) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_state_q     <= WrData;
      rd_state_q     <= RdIdle;
      full_q         <= '0;
      wr_bank_q      <= 1'b0;
      rd_bank_q      <= 1'b0;
      wcnt_q         <= '0;
      len_words_q[0] <= '0;
      len_words_q[1] <= '0;
      rptr_q         <= '0;
      tvalid_q       <= 1'b0;
      tlast_q        <= 1'b0;
      rx_len_q       <= '0;
      drop_cnt_q     <= '0;
      run_q          <= 1'b0;
    end else begin
      wr_state_q     <= wr_state_d;
      rd_state_q     <= rd_state_d;
      full_q         <= full_d;
      wr_bank_q      <= wr_bank_d;
      rd_bank_q      <= rd_bank_d;
      wcnt_q         <= wcnt_d;
      len_words_q[0] <= len_words_d[0];
      len_words_q[1] <= len_words_d[1];
      rptr_q         <= rptr_d;
      tvalid_q       <= tvalid_d;
      tlast_q        <= tlast_d;
      rx_len_q       <= rx_len_d;
      drop_cnt_q     <= drop_cnt_d;
      run_q          <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_addr] <= s_axis_tdata;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      tdata_q <= '0;
    end else if (rd_en) begin
      tdata_q <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_udp_rx_fifo.sv
// Directed testbench for udp_rx_fifo: checks reset values, verdict handling,
// oversize discard, bank back-pressure, stalled output and mid-frame reset.
module tb_udp_rx_fifo;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic        frame_ok = 1'b0;
  logic        frame_err = 1'b0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b1;
  logic [15:0] rx_len;
  logic [15:0] drop_cnt;

  udp_rx_fifo dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .frame_ok      (frame_ok),
    .frame_err     (frame_err),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .rx_len        (rx_len),
    .drop_cnt      (drop_cnt)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [15:0] len;
    int          cyc;
  } beat_t;

  beat_t q[$];
  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int cyc = 0;
  int stalls = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: collect handshaken beats and check stability during stalls.
  initial begin
    logic        stall;
    logic [31:0] pdata;
    logic        plast;
    stall = 1'b0;
    pdata = '0;
    plast = 1'b0;
    forever begin
      @(negedge aclk);
      cyc++;
      if (!aresetn) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("stall_valid", {31'b0, m_axis_tvalid}, 32'd1);
          chk("stall_data", m_axis_tdata, pdata);
          chk("stall_last", {31'b0, m_axis_tlast}, {31'b0, plast});
        end
        if (m_axis_tvalid && m_axis_tready) begin
          q.push_back('{data: m_axis_tdata, last: m_axis_tlast, len: rx_len, cyc: cyc});
        end
        stall = m_axis_tvalid && !m_axis_tready;
        pdata = m_axis_tdata;
        plast = m_axis_tlast;
      end
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic last, input logic ok,
                           input logic err);
    int guard;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    frame_ok      = ok;
    frame_err     = err;
    guard = 0;
    @(negedge aclk);
    while (!s_axis_tready && guard < 1000) begin
      stalls++;
      guard++;
      @(negedge aclk);
    end
    chk("s_tready_wait", {31'b0, s_axis_tready}, 32'd1);
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    frame_ok      = 1'b0;
    frame_err     = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] base, input int n, input logic ok,
                            input logic err);
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      send_beat(base + i, i == n - 1, ok && (i == n - 1), err && (i == n - 1));
    end
  endtask

  task automatic expect_frame(input string tag, input logic [31:0] base, input int n,
                              input logic [15:0] len, input bit consec);
    int guard;
    int bad_data;
    int bad_last;
    int bad_len;
    guard = 0;
    while (q.size() < n && guard < 5000) begin
      @(posedge aclk);
      #1;
      guard++;
    end
    chk({tag, "_count"}, {31'b0, q.size() >= n}, 32'd1);
    if (q.size() >= n) begin
      bad_data = 0;
      bad_last = 0;
      bad_len  = 0;
      for (int i = 0; i < n; i++) begin
        if (q[i].data !== base + i) bad_data++;
        if (q[i].last !== (i == n - 1)) bad_last++;
        if (q[i].len !== len) bad_len++;
      end
      chk({tag, "_data_errs"}, bad_data, 0);
      chk({tag, "_tlast_errs"}, bad_last, 0);
      chk({tag, "_rxlen_errs"}, bad_len, 0);
      if (consec) chk({tag, "_consecutive"}, q[n-1].cyc - q[0].cyc, n - 1);
      for (int i = 0; i < n; i++) void'(q.pop_front());
    end else begin
      q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_tready"}, {31'b0, s_axis_tready}, 32'd0);
    chk({tag, "_m_tvalid"}, {31'b0, m_axis_tvalid}, 32'd0);
    chk({tag, "_m_tlast"}, {31'b0, m_axis_tlast}, 32'd0);
    chk({tag, "_m_tdata"}, m_axis_tdata, 32'd0);
    chk({tag, "_rx_len"}, {16'b0, rx_len}, 32'd0);
    chk({tag, "_drop_cnt"}, {16'b0, drop_cnt}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values.
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check_reset_outputs("reset");
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;

    // 1: 4-word good frame, verdict with tlast; tvalid rises 2 cycles after commit.
    send_frame(32'hA0, 4, 1'b1, 1'b0);
    chk("t1_valid_commit_plus1", {31'b0, m_axis_tvalid}, 32'd0);
    @(posedge aclk);
    #1;
    chk("t1_valid_commit_plus2", {31'b0, m_axis_tvalid}, 32'd1);
    chk("t1_first_data", m_axis_tdata, 32'hA0);
    expect_frame("t1", 32'hA0, 4, 16'd16, 1'b1);
    chk("t1_drop_cnt", {16'b0, drop_cnt}, 32'd0);

    // 2: 3-word frame, frame_err two cycles after tlast.
    send_frame(32'hB0, 3, 1'b0, 1'b0);
    chk("t2_tready_verdict1", {31'b0, s_axis_tready}, 32'd0);
    @(posedge aclk);
    #1;
    chk("t2_tready_verdict2", {31'b0, s_axis_tready}, 32'd0);
    frame_err = 1'b1;
    @(posedge aclk);
    #1;
    frame_err = 1'b0;
    chk("t2_tready_after", {31'b0, s_axis_tready}, 32'd1);
    chk("t2_drop_cnt", {16'b0, drop_cnt}, 32'd1);
    repeat (5) @(posedge aclk);
    #1;
    chk("t2_no_output", q.size(), 0);
    send_frame(32'hC0, 2, 1'b1, 1'b0);
    expect_frame("t2b", 32'hC0, 2, 16'd8, 1'b1);

    // 3: 300-word oversize frame is sunk and dropped; later frame_ok is ignored.
    send_frame(32'h1000, 300, 1'b1, 1'b0);
    chk("t3_no_stall", stalls, 0);
    chk("t3_drop_cnt", {16'b0, drop_cnt}, 32'd2);
    frame_ok = 1'b1;
    @(posedge aclk);
    #1;
    frame_ok = 1'b0;
    repeat (6) @(posedge aclk);
    #1;
    chk("t3_no_output", q.size(), 0);
    chk("t3_drop_cnt_after_ok", {16'b0, drop_cnt}, 32'd2);
    chk("t3_tready", {31'b0, s_axis_tready}, 32'd1);

    // 4: both banks fill while the sink stalls; third frame waits for a free bank.
    m_axis_tready = 1'b0;
    send_frame(32'h4100, 8, 1'b1, 1'b0);
    send_frame(32'h4200, 8, 1'b1, 1'b0);
    chk("t4_tready_full", {31'b0, s_axis_tready}, 32'd0);
    repeat (5) @(posedge aclk);
    #1;
    chk("t4_tready_still_full", {31'b0, s_axis_tready}, 32'd0);
    chk("t4_no_output_stalled", q.size(), 0);
    m_axis_tready = 1'b1;
    send_frame(32'h4300, 8, 1'b1, 1'b0);
    chk("t4_frame3_waited", {31'b0, stalls > 0}, 32'd1);
    expect_frame("t4f1", 32'h4100, 8, 16'd32, 1'b1);
    expect_frame("t4f2", 32'h4200, 8, 16'd32, 1'b1);
    expect_frame("t4f3", 32'h4300, 8, 16'd32, 1'b1);

    // 5: full 256-word frame under random sink back-pressure.
    fork
      send_frame(32'h5000, 256, 1'b1, 1'b0);
      begin
        int g;
        g = 0;
        while (q.size() < 256 && g < 4000) begin
          @(posedge aclk);
          #1;
          m_axis_tready = 1'($urandom_range(0, 1));
          g++;
        end
      end
    join
    m_axis_tready = 1'b1;
    expect_frame("t5", 32'h5000, 256, 16'd1024, 1'b0);

    // 6: reset in the middle of output.
    send_frame(32'h600, 10, 1'b1, 1'b0);
    repeat (5) @(posedge aclk);
    #1;
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    check_reset_outputs("t6_reset");
    aresetn = 1'b1;
    q.delete();
    repeat (5) @(posedge aclk);
    #1;
    chk("t6_no_output_after_reset", q.size(), 0);
    chk("t6_tvalid_after_reset", {31'b0, m_axis_tvalid}, 32'd0);
    send_frame(32'h700, 2, 1'b1, 1'b0);
    expect_frame("t6b", 32'h700, 2, 16'd8, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
